// File: rtl/m1_frame_sequencer_if.sv
// Handshake and serial bundle between the frame timing side, the M1 word
// filler and the M16 serializer. The sequencer uses the slave view; whoever
// drives frame requests and returns filler words uses the master view.
interface m1_frame_sequencer_if;
    logic        enable;
    logic        frameStart;
    logic [11:0] dataWord;
    logic        bufGetWord;
    logic [6:0]  bufRdPointer;
    logic        serOut;
    logic        serEn;
    logic        busy;
    logic        frameDone;
    logic        frameOverrun;

    modport master (
        output enable,
        output frameStart,
        output dataWord,
        input  bufGetWord,
        input  bufRdPointer,
        input  serOut,
        input  serEn,
        input  busy,
        input  frameDone,
        input  frameOverrun
    );

    modport slave (
        input  enable,
        input  frameStart,
        input  dataWord,
        output bufGetWord,
        output bufRdPointer,
        output serOut,
        output serEn,
        output busy,
        output frameDone,
        output frameOverrun
    );
endinterface

// File: rtl/m1_frame_sequencer.sv
// M1 frame sequencer: walks slots 0..127 of one telemetry frame per accepted
// frame request, fetching each 12-bit word from the filler and shifting it out
// MSB-first, each bit held for BIT_DIV clocks.
module m1_frame_sequencer #(
    parameter int BIT_DIV = 4
) (
    input logic                 clk,
    input logic                 reset,
    m1_frame_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    // Divider counts 0..BIT_DIV-1; the last value ends the current bit.
    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [6:0] LAST_SLOT = 7'd127;

    state_t      state_reg, state_next;
    logic [6:0]  ptr_reg, ptr_next;
    logic [11:0] shift_reg, shift_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  div_reg, div_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        accept;

    // A request is taken only from IDLE once the previous frame has fully
    // retired; busy stays high through the frameDone cycle, so a request in
    // that cycle is an overrun rather than a new frame.
    assign accept = bus.frameStart && bus.enable && !busy_reg;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            div_reg     <= div_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic: fetch, wait one cycle for the filler, then shift 12 bits.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        div_next     = div_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Also retires the busy flag held through the frameDone cycle.
                busy_next = 1'b0;
                if (accept) begin
                    state_next = FETCH;
                    ptr_next   = '0;
                    busy_next  = 1'b1;
                end
            end

            FETCH: begin
                state_next = WAIT;
            end

            WAIT: begin
                // Filler word is valid during this cycle.
                shift_next   = bus.dataWord;
                bit_cnt_next = 4'd11;
                div_next     = '0;
                state_next   = SHIFT;
            end

            SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (bit_cnt_reg == 4'd0) begin
                        if (ptr_reg == LAST_SLOT) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            ptr_next   = ptr_reg + 7'd1;
                            state_next = FETCH;
                        end
                    end else begin
                        shift_next   = {shift_reg[10:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg - 4'd1;
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.bufGetWord   = (state_reg == FETCH);
    assign bus.bufRdPointer = ptr_reg;
    assign bus.serEn        = (state_reg == SHIFT);
    assign bus.serOut       = (state_reg == SHIFT) && shift_reg[11];
    assign bus.busy         = busy_reg;
    assign bus.frameDone    = done_reg;
    // Overrun is flagged in the same cycle the unwanted request is sampled.
    assign bus.frameOverrun = bus.frameStart && busy_reg;

endmodule

// File: tb/tb_m1_frame_sequencer.sv
// Bench for m1_frame_sequencer: two instances (BIT_DIV 4 and 1) driven side by
// side and compared every cycle against a timeline model derived from the
// frame arithmetic (word period, slot index, bit index within a word).
module tb_m1_frame_sequencer;

    logic clk = 1'b1;
    logic reset;

    m1_frame_sequencer_if bus4();
    m1_frame_sequencer_if bus1();

    m1_frame_sequencer #(.BIT_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    m1_frame_sequencer #(.BIT_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          c1 [2];
    logic [11:0] words [2][128];

    int          strobes [2];
    int          done_cnt [2];
    int          done_cyc [2];
    int          ovr_cnt [2];
    int          busy_cnt [2];
    int          ser_cnt [2];
    int          max_ptr [2];
    int          first_ptr [2];
    logic        get_seen [2];
    logic [6:0]  ptr_seen [2];

    bit          collect;
    logic [47:0] got5;
    int          n5;
    logic [23:0] stream1;
    int          n1;
    int          last_s2;
    int          first_s3;

    function automatic int dv(int idx);
        return (idx == 0) ? 4 : 1;
    endfunction

    function automatic logic fs_of(int idx);
        return (idx == 0) ? bus4.frameStart : bus1.frameStart;
    endfunction

    function automatic logic en_of(int idx);
        return (idx == 0) ? bus4.enable : bus1.enable;
    endfunction

    // {bufGetWord, serOut, serEn, busy, frameDone, frameOverrun}
    function automatic logic [5:0] act_vec(int idx);
        if (idx == 0)
            return {bus4.bufGetWord, bus4.serOut, bus4.serEn, bus4.busy, bus4.frameDone, bus4.frameOverrun};
        return {bus1.bufGetWord, bus1.serOut, bus1.serEn, bus1.busy, bus1.frameDone, bus1.frameOverrun};
    endfunction

    function automatic logic [6:0] act_ptr(int idx);
        return (idx == 0) ? bus4.bufRdPointer : bus1.bufRdPointer;
    endfunction

    // Expected outputs from the time elapsed since C1 of the current frame.
    function automatic logic [5:0] exp_vec(int idx);
        int   p;
        int   t;
        int   k;
        int   r;
        logic fsv;
        p   = 2 + 12 * dv(idx);
        fsv = fs_of(idx);
        if (reset || c1[idx] < 0) return 6'b0;
        t = cyc - c1[idx];
        if (t < 0 || t > 128 * p) return 6'b0;
        if (t == 128 * p) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, fsv};
        k = t / p;
        r = t % p;
        if (r == 0) return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fsv};
        if (r == 1) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fsv};
        return {1'b0, words[idx][k][11 - (r - 2) / dv(idx)], 1'b1, 1'b1, 1'b0, fsv};
    endfunction

    // Expected pointer, or -1 where the pointer is not defined (between frames).
    function automatic int exp_ptr(int idx);
        int p;
        int t;
        p = 2 + 12 * dv(idx);
        if (reset || c1[idx] < 0) return 0;
        t = cyc - c1[idx];
        if (t >= 0 && t < 128 * p) return t / p;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            strobes[i]   = 0;
            done_cnt[i]  = 0;
            done_cyc[i]  = -1;
            ovr_cnt[i]   = 0;
            busy_cnt[i]  = 0;
            ser_cnt[i]   = 0;
            max_ptr[i]   = -1;
            first_ptr[i] = -1;
        end
        got5     = '0;
        n5       = 0;
        stream1  = '0;
        n1       = 0;
        last_s2  = -1;
        first_s3 = -1;
    endtask

    // One clock: check at negedge, advance the model at posedge, then drive
    // the filler response and clear single-cycle request pulses.
    task automatic tick();
        logic [5:0] av;
        logic [5:0] ev;
        logic [6:0] ap;
        int         ep;
        @(negedge clk);
        for (int idx = 0; idx < 2; idx++) begin
            av = act_vec(idx);
            ev = exp_vec(idx);
            ap = act_ptr(idx);
            ep = exp_ptr(idx);
            chk($sformatf("outputs dut%0d cyc %0d", idx, cyc), 48'(av), 48'(ev));
            if (ep >= 0) chk($sformatf("pointer dut%0d cyc %0d", idx, cyc), 48'(ap), 48'(ep));
            if (av[5]) begin
                strobes[idx]++;
                if (first_ptr[idx] < 0) first_ptr[idx] = int'(ap);
                if (int'(ap) > max_ptr[idx]) max_ptr[idx] = int'(ap);
            end
            if (av[1]) begin
                done_cnt[idx]++;
                done_cyc[idx] = cyc;
            end
            if (av[0]) ovr_cnt[idx]++;
            if (av[2]) busy_cnt[idx]++;
            if (av[3]) ser_cnt[idx]++;
            get_seen[idx] = av[5];
            ptr_seen[idx] = ap;
            if (collect && idx == 0 && av[3] && ap == 7'd5) begin
                got5 = {got5[46:0], av[4]};
                n5++;
            end
            if (collect && idx == 1 && av[3]) begin
                if (ap == 7'd2) begin
                    stream1 = {stream1[22:0], av[4]};
                    n1++;
                    last_s2 = cyc;
                end else if (ap == 7'd3) begin
                    stream1 = {stream1[22:0], av[4]};
                    n1++;
                    if (first_s3 < 0) first_s3 = cyc;
                end
            end
        end
        @(posedge clk);
        for (int idx = 0; idx < 2; idx++) begin
            ev = exp_vec(idx);
            if (reset) c1[idx] = -1;
            else if (fs_of(idx) && en_of(idx) && !ev[2]) c1[idx] = cyc + 1;
        end
        cyc++;
        #1;
        bus4.frameStart = 1'b0;
        bus1.frameStart = 1'b0;
        bus4.dataWord = get_seen[0] ? words[0][ptr_seen[0]] : 12'hA5A;
        bus1.dataWord = get_seen[1] ? words[1][ptr_seen[1]] : 12'hA5A;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [11:0] w5;
        logic [47:0] exp5;
        logic [23:0] exp_st;
        int          c1s4;
        int          c1s1;

        c1[0] = -1;
        c1[1] = -1;
        get_seen[0] = 1'b0;
        get_seen[1] = 1'b0;
        ptr_seen[0] = '0;
        ptr_seen[1] = '0;
        collect = 1'b0;
        for (int k = 0; k < 128; k++) begin
            words[0][k] = 12'(k);
            words[1][k] = 12'($urandom_range(0, 4095));
        end
        reset = 1'b1;
        bus4.enable = 1'b1;
        bus1.enable = 1'b1;
        bus4.frameStart = 1'b0;
        bus1.frameStart = 1'b0;
        bus4.dataWord = 12'hA5A;
        bus1.dataWord = 12'hA5A;
        clear_mon();

        // Reset while running, then quiet for 100 clocks.
        ticks(3);
        reset = 1'b0;
        bus4.frameStart = 1'b1;
        bus1.frameStart = 1'b1;
        ticks(20);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        clear_mon();
        ticks(100);
        chk("quiet after reset", 48'(strobes[0] + strobes[1] + busy_cnt[0] + busy_cnt[1] + ser_cnt[0] + ser_cnt[1] + done_cnt[0] + done_cnt[1]), 48'd0);

        // Full frames: ramp words on BIT_DIV=4, random words with fixed slots 2/3 on BIT_DIV=1.
        words[1][2] = 12'h378;
        words[1][3] = 12'h6F0;
        clear_mon();
        collect = 1'b1;
        bus4.frameStart = 1'b1;
        bus1.frameStart = 1'b1;
        tick();
        c1s4 = c1[0];
        c1s1 = c1[1];
        ticks(6405);
        collect = 1'b0;
        chk("div4 frameDone count", 48'(done_cnt[0]), 48'd1);
        chk("div4 frameDone offset", 48'(done_cyc[0] - c1s4), 48'd6400);
        chk("div4 strobe count", 48'(strobes[0]), 48'd128);
        w5 = 12'h005;
        exp5 = '0;
        for (int j = 0; j < 12; j++)
            for (int q = 0; q < 4; q++) exp5 = {exp5[46:0], w5[11 - j]};
        chk("div4 slot5 bit count", 48'(n5), 48'd48);
        chk("div4 slot5 stream", got5, exp5);
        exp_st = 24'b001101111000_011011110000;
        chk("div1 frameDone offset", 48'(done_cyc[1] - c1s1), 48'(128 * 14));
        chk("div1 strobe count", 48'(strobes[1]), 48'd128);
        chk("div1 slot2/3 bit count", 48'(n1), 48'd24);
        chk("div1 slot2/3 stream", 48'(stream1), 48'(exp_st));
        chk("div1 serEn gap", 48'(first_s3 - last_s2 - 1), 48'd2);

        // Overrun on BIT_DIV=1; enable gating on BIT_DIV=4 at the same time.
        for (int k = 0; k < 128; k++) words[1][k] = 12'($urandom_range(0, 4095));
        clear_mon();
        bus4.enable = 1'b0;
        bus4.frameStart = 1'b1;
        bus1.frameStart = 1'b1;
        tick();
        while (cyc < c1[1] + 100) tick();
        bus1.frameStart = 1'b1;
        bus4.frameStart = 1'b1;
        tick();
        while (cyc < c1[1] + 128 * 14) tick();
        bus1.frameStart = 1'b1;
        tick();
        ticks(30);
        chk("overrun pulses", 48'(ovr_cnt[1]), 48'd2);
        chk("overrun frameDone count", 48'(done_cnt[1]), 48'd1);
        chk("overrun strobe count", 48'(strobes[1]), 48'd128);
        chk("gated busy cycles", 48'(busy_cnt[0]), 48'd0);
        chk("gated strobes", 48'(strobes[0]), 48'd0);

        // Enable dropped mid-frame at slot 60: frame still completes.
        bus4.enable = 1'b1;
        for (int k = 0; k < 128; k++) words[1][k] = 12'($urandom_range(0, 4095));
        clear_mon();
        bus1.frameStart = 1'b1;
        tick();
        while (cyc < c1[1] + 60 * 14 + 5) tick();
        bus1.enable = 1'b0;
        while (cyc < c1[1] + 128 * 14 + 3) tick();
        chk("late disable frameDone count", 48'(done_cnt[1]), 48'd1);
        chk("late disable strobe count", 48'(strobes[1]), 48'd128);
        chk("late disable last slot", 48'(max_ptr[1]), 48'd127);
        clear_mon();
        bus1.frameStart = 1'b1;
        ticks(5);
        chk("disabled request busy", 48'(busy_cnt[1]), 48'd0);

        // Mid-frame reset at slot 64, bit counter 7.
        bus1.enable = 1'b1;
        clear_mon();
        bus1.frameStart = 1'b1;
        tick();
        while (cyc < c1[1] + 64 * 14 + 6) tick();
        reset = 1'b1;
        #1;
        chk("reset outputs immediate", 48'(act_vec(1)), 48'd0);
        chk("reset pointer immediate", 48'(act_ptr(1)), 48'd0);
        tick();
        reset = 1'b0;
        clear_mon();
        ticks(60);
        chk("no frameDone after reset", 48'(done_cnt[1]), 48'd0);
        chk("no serial after reset", 48'(ser_cnt[1]), 48'd0);
        bus1.frameStart = 1'b1;
        ticks(128 * 14 + 5);
        chk("restart first pointer", 48'(first_ptr[1]), 48'd0);
        chk("restart strobe count", 48'(strobes[1]), 48'd128);
        chk("restart frameDone count", 48'(done_cnt[1]), 48'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
